// File: rtl/mul4_seq_ctrl_if.sv
// Request, response and multiplier-port bundle for mul4_seq_ctrl.
// The slave modport is the controller; master is the requester/consumer/multiplier side.
interface mul4_seq_ctrl_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_x;
    logic [3:0] req0_y;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_x;
    logic [3:0] req1_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_product;
    logic [1:0] mul_x;
    logic [1:0] mul_y;
    logic [3:0] mul_p;
    logic       busy;

    modport slave (
        input  req0_valid, req0_x, req0_y,
        input  req1_valid, req1_x, req1_y,
        input  rsp_ready, mul_p,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_product,
        output mul_x, mul_y, busy
    );

    modport master (
        output req0_valid, req0_x, req0_y,
        output req1_valid, req1_x, req1_y,
        output rsp_ready, mul_p,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_product,
        input  mul_x, mul_y, busy
    );
endinterface

// File: rtl/mul4_seq_ctrl.sv
// 4x4 unsigned multiply sequenced over a shared external 2x2 multiplier, two arbitrated requesters.
// Latency: accept at E0, digit steps at E1..E4, rsp_valid after E4; minimum issue interval 6 cycles.
// Backpressure: result held in DONE until rsp_ready; requests only accepted in IDLE. MUL4_RR_ARB_EN selects round-robin.
module mul4_seq_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    mul4_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] step_q;
    logic [3:0] x_q, y_q;
    logic       id_q;
    logic [7:0] acc_q;
    logic [7:0] partial;
    logic       grant1;
    logic       accept;

`ifdef MUL4_RR_ARB_EN
    logic last_q;

    // On a tie the requester not served last wins; resetting to 1 lets requester 0 win the first tie.
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant1;
        end
    end
`else
    assign grant1 = bus.req1_valid && !bus.req0_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.busy       = 1'b0;
        bus.mul_x      = 2'd0;
        bus.mul_y      = 2'd0;
        case (state_q)
            ST_IDLE: begin
                bus.req0_ready = bus.req0_valid && !grant1;
                bus.req1_ready = grant1;
                accept         = bus.req0_valid || bus.req1_valid;
                if (accept) begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                bus.busy  = 1'b1;
                bus.mul_x = step_q[1] ? x_q[3:2] : x_q[1:0];
                bus.mul_y = step_q[0] ? y_q[3:2] : y_q[1:0];
                if (step_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.busy      = 1'b1;
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The two cross steps pair a low digit with a high digit, so both carry weight 4.
    always_comb begin
        partial = {2'd0, bus.mul_p, 2'd0};
        case (step_q)
            2'd0:    partial = {4'd0, bus.mul_p};
            2'd3:    partial = {bus.mul_p, 4'd0};
            default: partial = {2'd0, bus.mul_p, 2'd0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 2'd0;
            x_q    <= 4'd0;
            y_q    <= 4'd0;
            id_q   <= 1'b0;
            acc_q  <= 8'd0;
        end else if (accept) begin
            x_q    <= grant1 ? bus.req1_x : bus.req0_x;
            y_q    <= grant1 ? bus.req1_y : bus.req0_y;
            id_q   <= grant1;
            acc_q  <= 8'd0;
            step_q <= 2'd0;
        end else if (state_q == ST_MUL) begin
            acc_q  <= acc_q + partial;
            step_q <= step_q + 2'd1;
        end
    end

    assign bus.rsp_product = acc_q;
    assign bus.rsp_id      = id_q;
endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Bench for mul4_seq_ctrl: vector table, step trace, exhaustive sweep, contention, stall, reset, random.
module tb_mul4_seq_ctrl;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    mul4_seq_ctrl_if bus ();

    mul4_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural 2x2 multiplier that the controller drives.
    assign bus.mul_p = {2'd0, bus.mul_x} * {2'd0, bus.mul_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         id;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] prod;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from requester id with rsp_ready held high.
    task automatic txn(input bit id, input logic [3:0] x, input logic [3:0] y,
                       input logic [7:0] exp, output int acc_cyc);
        int  n;
        bit  ok;
        int  lat;
        bus.rsp_ready = 1'b1;
        if (id) begin
            bus.req1_x = x; bus.req1_y = y; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_x = x; bus.req0_y = y; bus.req0_valid = 1'b1;
        end
        ok = 1'b0;
        acc_cyc = 0;
        n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("txn_accept", ok, 1);
        if (!ok) return;
        ok = 1'b0;
        n = 0;
        lat = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                lat = cyc - acc_cyc;
            end
            n++;
        end
        check("txn_rsp_seen", ok, 1);
        check("txn_latency", lat, 5);
        check("txn_product", bus.rsp_product, exp);
        check("txn_id", bus.rsp_id, id);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [8];
        logic [1:0] tmx [4];
        logic [1:0] tmy [4];
        logic [3:0] tmp [4];
        int         exp_seq [4];
        int         acc_c, prev_c, k, n;
        logic [3:0] xv, yv;
        bit         m_act, m_id, m_last;
        int         m_cnt, g;
        logic [3:0] m_x, m_y;

        tbl[0] = '{1'b0, 4'd15, 4'd15, 8'd225};
        tbl[1] = '{1'b0, 4'd11, 4'd6,  8'd66};
        tbl[2] = '{1'b1, 4'd7,  4'd9,  8'd63};
        tbl[3] = '{1'b0, 4'd0,  4'd0,  8'd0};
        tbl[4] = '{1'b1, 4'd15, 4'd0,  8'd0};
        tbl[5] = '{1'b0, 4'd1,  4'd15, 8'd15};
        tbl[6] = '{1'b1, 4'd12, 4'd13, 8'd156};
        tbl[7] = '{1'b0, 4'd10, 4'd5,  8'd50};

        bus.req0_valid = 1'b0; bus.req0_x = 4'd0; bus.req0_y = 4'd0;
        bus.req1_valid = 1'b0; bus.req1_x = 4'd0; bus.req1_y = 4'd0;
        bus.rsp_ready  = 1'b0;
        do_reset();

        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_product", bus.rsp_product, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req1_ready", bus.req1_ready, 0);
        check("rst_mul_x", bus.mul_x, 0);
        check("rst_mul_y", bus.mul_y, 0);
        check("rst_busy", bus.busy, 0);

        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].id, tbl[i].x, tbl[i].y, tbl[i].prod, acc_c);
        end
        check("busy_after_txn", bus.busy, 0);

        // Digit-step trace of 0xB * 6.
        tmx[0] = 2'd3; tmx[1] = 2'd3; tmx[2] = 2'd2; tmx[3] = 2'd2;
        tmy[0] = 2'd2; tmy[1] = 2'd1; tmy[2] = 2'd2; tmy[3] = 2'd1;
        tmp[0] = 4'd6; tmp[1] = 4'd3; tmp[2] = 4'd4; tmp[3] = 4'd2;
        bus.rsp_ready = 1'b1;
        bus.req0_x = 4'hB; bus.req0_y = 4'h6; bus.req0_valid = 1'b1;
        @(negedge clk);
        check("trace_ready", bus.req0_ready, 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check("trace_mul_x", bus.mul_x, tmx[s]);
            check("trace_mul_y", bus.mul_y, tmy[s]);
            check("trace_mul_p", bus.mul_p, tmp[s]);
        end
        @(negedge clk);
        check("trace_rsp_valid", bus.rsp_valid, 1);
        check("trace_product", bus.rsp_product, 66);
        @(posedge clk); #1;
        check("trace_busy_after", bus.busy, 0);

        // Exhaustive sweep on requester 1, back to back.
        prev_c = 0;
        for (int i = 0; i < 256; i++) begin
            xv = i[7:4];
            yv = i[3:0];
            txn(1'b1, xv, yv, 8'(int'(xv) * int'(yv)), acc_c);
            if (i > 0) check("sweep_interval", acc_c - prev_c, 6);
            prev_c = acc_c;
        end

        // Contention: both requesters valid continuously.
        do_reset();
`ifdef MUL4_RR_ARB_EN
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
`else
        exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif
        bus.req0_x = 4'd3; bus.req0_y = 4'd5;
        bus.req1_x = 4'd14; bus.req1_y = 4'd11;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        k = 0;
        n = 0;
        while (k < 4 && n < 80) begin
            @(negedge clk);
            check("cont_one_ready", 32'(bus.req0_ready && bus.req1_ready), 0);
            if (bus.rsp_valid === 1'b1) begin
                check("cont_id", bus.rsp_id, exp_seq[k]);
                check("cont_product", bus.rsp_product, bus.rsp_id ? 154 : 15);
                k++;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        check("cont_count", k, 4);
        repeat (8) @(posedge clk);
        #1;

        // Response stall in DONE.
        bus.rsp_ready = 1'b0;
        bus.req1_x = 4'd9; bus.req1_y = 4'd13; bus.req1_valid = 1'b1;
        @(negedge clk);
        check("stall_accept", bus.req1_ready, 1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_rsp_valid", bus.rsp_valid, 1);
        bus.req0_x = 4'd2; bus.req0_y = 4'd3; bus.req0_valid = 1'b1;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            check("stall_hold_valid", bus.rsp_valid, 1);
            check("stall_hold_product", bus.rsp_product, 117);
            check("stall_hold_id", bus.rsp_id, 1);
            check("stall_ready0", bus.req0_ready, 0);
            check("stall_ready1", bus.req1_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_next_ready", bus.req0_ready, 1);
        check("stall_next_busy", bus.busy, 0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_next_valid", bus.rsp_valid, 1);
        check("stall_next_product", bus.rsp_product, 6);
        check("stall_next_id", bus.rsp_id, 0);
        @(posedge clk); #1;

        // Reset pulsed during step 2.
        bus.req0_x = 4'd15; bus.req0_y = 4'd15; bus.req0_valid = 1'b1;
        @(negedge clk);
        check("rstmid_accept", bus.req0_ready, 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_step2_x", bus.mul_x, 3);
        check("rstmid_step2_y", bus.mul_y, 3);
        rst_n = 1'b0;
        #1;
        check("rstmid_rsp_valid", bus.rsp_valid, 0);
        check("rstmid_mul_x", bus.mul_x, 0);
        check("rstmid_mul_y", bus.mul_y, 0);
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_product", bus.rsp_product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            check("rstmid_no_rsp", bus.rsp_valid, 0);
        end
        @(posedge clk); #1;
        txn(1'b0, 4'd7, 4'd9, 8'd63, acc_c);

        // Randomized traffic against a cycle-level reference of the protocol.
        do_reset();
        m_act = 1'b0; m_cnt = 0; m_id = 1'b0; m_last = 1'b1; m_x = 4'd0; m_y = 4'd0;
        for (int c = 0; c < 400; c++) begin
            if (!bus.req0_valid && $urandom_range(0, 2) == 0) begin
                bus.req0_valid = 1'b1;
                bus.req0_x = 4'($urandom_range(0, 15));
                bus.req0_y = 4'($urandom_range(0, 15));
            end
            if (!bus.req1_valid && $urandom_range(0, 2) == 0) begin
                bus.req1_valid = 1'b1;
                bus.req1_x = 4'($urandom_range(0, 15));
                bus.req1_y = 4'($urandom_range(0, 15));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = -1;
            if (!m_act) begin
                if (bus.req0_valid && bus.req1_valid) begin
`ifdef MUL4_RR_ARB_EN
                    g = m_last ? 0 : 1;
`else
                    g = 0;
`endif
                end else if (bus.req0_valid) begin
                    g = 0;
                end else if (bus.req1_valid) begin
                    g = 1;
                end
            end
            check("rnd_ready0", bus.req0_ready, g == 0);
            check("rnd_ready1", bus.req1_ready, g == 1);
            check("rnd_busy", bus.busy, m_act);
            check("rnd_rsp_valid", bus.rsp_valid, m_act && m_cnt == 4);
            if (m_act && m_cnt < 4) begin
                check("rnd_mul_x", bus.mul_x, (m_cnt >= 2) ? m_x[3:2] : m_x[1:0]);
                check("rnd_mul_y", bus.mul_y, (m_cnt == 1 || m_cnt == 3) ? m_y[3:2] : m_y[1:0]);
            end else begin
                check("rnd_mul_x_idle", bus.mul_x, 0);
                check("rnd_mul_y_idle", bus.mul_y, 0);
            end
            if (m_act && m_cnt == 4) begin
                check("rnd_product", bus.rsp_product, int'(m_x) * int'(m_y));
                check("rnd_id", bus.rsp_id, m_id);
            end
            if (g == 0) begin
                m_act = 1'b1; m_cnt = 0; m_x = bus.req0_x; m_y = bus.req0_y; m_id = 1'b0; m_last = 1'b0;
            end else if (g == 1) begin
                m_act = 1'b1; m_cnt = 0; m_x = bus.req1_x; m_y = bus.req1_y; m_id = 1'b1; m_last = 1'b1;
            end else if (m_act && m_cnt < 4) begin
                m_cnt++;
            end else if (m_act && bus.rsp_ready) begin
                m_act = 1'b0;
            end
            @(posedge clk); #1;
            if (g == 0) bus.req0_valid = 1'b0;
            if (g == 1) bus.req1_valid = 1'b0;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
